// File: rtl/mpi_rr_crossbar.sv
// N_PORT x N_PORT torus switch crossbar: per-output round-robin arbitration into a
// one-entry registered output stage, with discard-and-count of malformed direction codes.
module mpi_rr_crossbar #(
  parameter int N_PORT    = 6,
  parameter int FLIT_W    = 85,
  parameter int ROUTE_LEN = 3,
  parameter int PTR_W     = 3,
  parameter int DROP_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORT*FLIT_W-1:0]    in,
  input  logic [N_PORT*ROUTE_LEN-1:0] route_in,
  input  logic [N_PORT-1:0]           in_valid,
  input  logic [N_PORT-1:0]           out_avail,
  output logic [N_PORT-1:0]           in_avail,
  output logic [N_PORT-1:0]           out_valid,
  output logic [N_PORT*FLIT_W-1:0]    out,
  output logic [DROP_W-1:0]           drop_count
);

  localparam logic [ROUTE_LEN-1:0] MAX_CODE = ROUTE_LEN'(N_PORT);
  localparam logic [PTR_W:0]       N_WIDE   = (PTR_W+1)'(N_PORT);
  localparam logic [PTR_W-1:0]     LAST     = PTR_W'(N_PORT-1);

  function automatic logic [DROP_W-1:0] drop_inc(input logic [N_PORT-1:0] v);
    logic [DROP_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_PORT; i++) n = n + DROP_W'(v[i]);
    return n;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [DROP_W-1:0] b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [N_PORT-1:0] req      [N_PORT];
  logic [N_PORT-1:0] grant    [N_PORT];
  logic [PTR_W-1:0]  win_idx  [N_PORT];
  logic [FLIT_W-1:0] win_flit [N_PORT];
  logic [PTR_W-1:0]  rr_ptr   [N_PORT];
  logic [FLIT_W-1:0] flit_p0  [N_PORT];
  logic [N_PORT-1:0] vld_p0;
  logic [N_PORT-1:0] bad;
  logic [N_PORT-1:0] load_ok;

  // Stage 0 input side: decode direction codes into per-output request vectors
  always_comb begin
    logic [ROUTE_LEN-1:0] code;
    bad = '0;
    for (int j = 0; j < N_PORT; j++) req[j] = '0;
    for (int i = 0; i < N_PORT; i++) begin
      code   = route_in[i*ROUTE_LEN +: ROUTE_LEN];
      bad[i] = in_valid[i] && !rst && (code == '0 || code > MAX_CODE);
      for (int j = 0; j < N_PORT; j++)
        req[j][i] = in_valid[i] && (code == ROUTE_LEN'(j+1));
    end
  end

  assign load_ok = ~vld_p0 | out_avail;

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    for (int j = 0; j < N_PORT; j++) begin
      grant[j]    = '0;
      win_idx[j]  = '0;
      win_flit[j] = '0;
      found       = 1'b0;
      for (int k = 0; k < N_PORT; k++) begin
        sum = {1'b0, rr_ptr[j]} + (PTR_W+1)'(k);
        if (sum >= N_WIDE) sum = sum - N_WIDE;
        idx = sum[PTR_W-1:0];
        if (!found && req[j][idx] && load_ok[j] && !rst) begin
          grant[j][idx] = 1'b1;
          win_idx[j]    = idx;
          found         = 1'b1;
        end
      end
      for (int i = 0; i < N_PORT; i++)
        if (grant[j][i]) win_flit[j] = in[i*FLIT_W +: FLIT_W];
    end
  end

  // Each input targets one output at most, so OR-ing grant rows never double-acks
  always_comb begin
    in_avail = bad;
    for (int j = 0; j < N_PORT; j++) in_avail = in_avail | grant[j];
  end

  // Stage 0 -> output register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= '0;
      drop_count <= '0;
      for (int j = 0; j < N_PORT; j++) begin
        rr_ptr[j]  <= '0;
        flit_p0[j] <= '0;
      end
    end else begin
      drop_count <= sat_add(drop_count, drop_inc(bad));
      for (int j = 0; j < N_PORT; j++) begin
        if (|grant[j]) begin
          flit_p0[j] <= win_flit[j];
          vld_p0[j]  <= 1'b1;
          rr_ptr[j]  <= ptr_next(win_idx[j]);
        end else if (out_avail[j]) begin
          vld_p0[j]  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld_p0;

  always_comb begin
    for (int j = 0; j < N_PORT; j++) out[j*FLIT_W +: FLIT_W] = flit_p0[j];
  end

endmodule

// File: doc/mpi_rr_crossbar.md
Name: mpi_rr_crossbar

Overview:
- Next-generation torus router switch stage: full N_PORT x N_PORT crossbar, replacing the two-output, fixed-reduction switch.
- Each input presents one flit plus a 3-bit direction code. Each output arbitrates round-robin among requesting inputs and registers the winner into a one-entry output stage with valid/avail flow control.
- Malformed direction codes are consumed, discarded and counted.
- Sits between the per-port input FIFOs and the link serialisers.

Parameters:
- N_PORT, 6, number of input ports and output ports; range 2..7.
- FLIT_W, 85, flit width including children field (82 flit + 3 children).
- ROUTE_LEN, 3, direction code width; code k in 1..N_PORT selects output k-1.
- PTR_W, 3, round-robin pointer width; must satisfy 2^PTR_W >= N_PORT.
- DROP_W, 16, drop counter width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in  input  N_PORT*FLIT_W  flattened flits; port i at [i*FLIT_W +: FLIT_W]
- route_in  input  N_PORT*ROUTE_LEN  flattened direction codes; port i at [i*ROUTE_LEN +: ROUTE_LEN]
- in_valid  input  N_PORT  flit present on input i
- out_avail  input  N_PORT  downstream on output j can take a flit this cycle (active high)
- in_avail  output  N_PORT  input i's flit is consumed this cycle (combinational)
- out_valid  output  N_PORT  registered, output j holds a flit
- out  output  N_PORT*FLIT_W  registered flattened output flits
- drop_count  output  DROP_W  saturating count of discarded flits

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1: in_avail=0. At the next edge: out_valid=0, out=0, all rr_ptr[j]=0, drop_count=0. Reset asserted mid-transfer discards every held flit; no flit is accepted in a reset cycle.
- Decode: req[j][i] = in_valid[i] && route_in[i]==j+1. Invalid code means in_valid[i] && (route_in[i]==0 || route_in[i]>N_PORT).
- Output stage load enable: load_ok[j] = !out_valid[j] || out_avail[j]. A full stage being drained this cycle can accept a new flit in the same cycle (no bubble).
- Arbitration, per output j, combinational:
  - Search inputs in order rr_ptr[j], rr_ptr[j]+1, ... modulo N_PORT.
  - The first i with req[j][i] is the winner, provided load_ok[j] is high.
  - grant[j][i] is one-hot or zero.
- Input handshake: in_avail[i] = OR over j of grant[j][i], or (invalid code on i). Each input can request only one output, so at most one grant per input. A flit with in_avail=0 must be held stable by the source.
- On grant[j][i] at an edge:
  - out[j] <= in[i], out_valid[j] <= 1.
  - rr_ptr[j] <= (i+1) mod N_PORT. The pointer wraps from N_PORT-1 to 0, never to values >= N_PORT.
- No grant, with out_valid[j] && out_avail[j]: out_valid[j] <= 0, out[j] holds its value, rr_ptr[j] unchanged.
- No grant, with out_valid[j] && !out_avail[j]: out[j] and out_valid[j] hold (backpressure). Any requesting inputs see in_avail=0.
- Latency: flit accepted at edge t appears on out_valid/out after edge t. One-cycle latency; throughput 1 flit per output per cycle.
- Fairness: with K inputs continuously requesting the same output and no backpressure, each is granted exactly once every K cycles.
- Drops: an invalid-code flit is accepted unconditionally (in_avail=1 regardless of outputs) and drop_count increments by 1. Multiple invalid inputs in one cycle increment by their popcount. The counter saturates at 2^DROP_W-1 and does not wrap.
- No combinational path from out_avail to out_valid. The out_avail to in_avail path is permitted.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=6'h3F, route=1 everywhere. Required: in_avail=0 throughout, and after release out_valid=0, out=0, drop_count=0.
- Parallel permutation: input i sends flit 0x100+i with route ((i+1) mod 6)+1, out_avail=all 1. Required: all in_avail=1 in one cycle; next cycle out_valid=6'h3F and output (i+1) mod 6 carries 0x100+i.
- Round-robin contention: inputs 0, 2, 5 hold route=1 continuously, out_avail[0]=1. Required: out[0] sequence from inputs 0,2,5,0,2,5, with exactly one in_avail high per cycle.
- Backpressure: load out[1] with flit A, then hold out_avail[1]=0 for 4 cycles while input 3 requests route 2. Required: out[1]=A stable, in_avail[3]=0. When out_avail[1]=1, flit B from input 3 appears the next cycle with no bubble.
- Drops and saturation: DROP_W=4, inputs 0 and 4 send route 0 and route 7 for 10 cycles. Required: in_avail[0]=in_avail[4]=1 every cycle, drop_count increases by 2 per cycle and saturates at 15, no out_valid asserted.
- Mid-operation reset: out_valid=6'h0F under backpressure, then pulse rst for 1 cycle. Required: out_valid=0 and rr_ptr=0 next cycle; after release, the first contention on output 0 between inputs 1 and 3 grants input 1 first.
